lcd_text_controller: RTL and testbench
======================================

Name: lcd_text_controller

Overview:
- Drives a 16x2 HD44780-compatible character LCD in 8-bit mode from the two 128-bit packed text lines produced by the display-text block.
- Runs the power-up/init command sequence, then writes line 1 and line 2 (16 characters each) to the panel.
- Takes a coherent snapshot of both lines per frame, and rewrites the panel only when the text changes.
- Sits between the display-text block and the board LCD pins.

Parameters:
- POWERUP_CYCLES, 2_000_000: wait after reset before the first command.
- E_PULSE_CYCLES, 25: width of lcd_e high, in clocks.
- CMD_WAIT_CYCLES, 2_500: post-write wait for every byte except clear.
- CLEAR_WAIT_CYCLES, 100_000: post-write wait after the clear command (0x01).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- line1  in  128  row 0 text; [127:120] = column 0, [7:0] = column 15
- line2  in  128  row 1 text, same packing
- force_refresh  in  1  1-cycle pulse; next frame is written even if text is unchanged
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_data  out  8  LCD data bus
- init_done  out  1  high after the init sequence completes; sticky until reset
- busy  out  1  high while any byte transfer or init is in progress
- frame_done  out  1  1-cycle pulse after the last character of line 2 is written

Behaviour:
- Reset (rst=0, asynchronous) values:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, init_done=0, busy=1, frame_done=0.
  - Shadow registers cleared to 8'h20 (all spaces); force-pending flag set.
  - State = S_PWR_WAIT.
- Reset asserted mid-transfer aborts at once: lcd_e drops to 0 asynchronously, and init restarts from S_PWR_WAIT.
- Byte transfer (common sub-sequence, fixed timing):
  - SETUP: 1 cycle. lcd_rs and lcd_data driven, lcd_e=0.
  - EHIGH: E_PULSE_CYCLES cycles, lcd_e=1.
  - HOLD: 1 cycle. lcd_e=0; rs and data are held.
  - WAIT: CMD_WAIT_CYCLES cycles, or CLEAR_WAIT_CYCLES for byte 0x01. rs and data are held.
  - Total = 2 + E_PULSE_CYCLES + wait cycles. lcd_rs/lcd_data change only in SETUP.
- FSM states:
  - S_PWR_WAIT: count POWERUP_CYCLES, then go to S_INIT.
  - S_INIT: issue commands 0x38 (function set), 0x0C (display on, cursor off), 0x06 (entry mode increment), 0x01 (clear), in that order, rs=0.
    - After the 0x01 wait completes: init_done=1, go to S_IDLE.
  - S_IDLE: busy=0.
    - Each cycle, compare {line1,line2} with the shadow registers.
    - If they differ, or force-pending=1: latch both inputs into the shadow, clear force-pending, go to S_ADDR1.
  - S_ADDR1: command 0x80 (DDRAM address 0x00), then S_CHAR1.
  - S_CHAR1: 16 data writes (rs=1) of shadow line1 columns 0..15; a 4-bit column counter wraps 15->0, then S_ADDR2.
  - S_ADDR2: command 0xC0 (DDRAM address 0x40), then S_CHAR2.
  - S_CHAR2: 16 data writes of shadow line2 columns 0..15.
    - After the last WAIT: frame_done=1 for 1 cycle, go to S_IDLE.
- Snapshot rules:
  - Input changes during a frame do not affect that frame.
  - The changed text is detected in S_IDLE after the frame ends, which starts a new frame.
- force_refresh:
  - Sets force-pending in any state, including during init or mid-frame.
  - A pulse coincident with the S_IDLE snapshot cycle is consumed by that snapshot (no extra frame).
  - force_refresh during reset is ignored.
- Because the reset shadow is all spaces with force-pending=1, the first frame after init is always written.
- busy=1 in every state except S_IDLE.
- All outputs are registered.

Test Plan (POWERUP_CYCLES=20, E_PULSE_CYCLES=2, CMD_WAIT_CYCLES=4, CLEAR_WAIT_CYCLES=10):
- Release reset, line1="PRESS * TO START", line2="MONEY: 01000    " -> 20 idle cycles.
  - Then bytes 0x38, 0x0C, 0x06 at 8-cycle spacing; 0x01 takes 14 cycles.
  - init_done rises; bus trace shows 0x80, 16 ASCII chars, 0xC0, 16 chars, all rs=1 for chars.
  - frame_done pulses once; 34 bytes x 8 cycles = 272 cycles after init_done.
- Hold inputs constant for 1000 cycles after frame_done -> no lcd_e pulses, busy=0.
- Change line2 column 11 from "0" to "5" -> exactly one new frame; the char-28 write carries 8'h35.
- Change line1 during the S_CHAR1 write of column 5 -> the current frame shows only the old text.
  - A second frame starts immediately after frame_done and carries the new text.
- Pulse force_refresh in S_IDLE with unchanged text -> one full 34-byte frame, identical data.
- Assert rst during EHIGH of a line-2 char -> lcd_e=0 in the same cycle, init_done=0.
  - After release, the full init sequence repeats, followed by a full frame.

Source files
------------

// File: rtl/lcd_text_controller.sv
// lcd_text_controller: drives a 16x2 HD44780-compatible character LCD in 8-bit
// mode. It runs the power-up and init command sequence, then writes both text
// lines whenever the snapshot taken in idle differs from the last frame shown,
// or a refresh has been forced.
module lcd_text_controller #(
  parameter int unsigned POWERUP_CYCLES    = 2_000_000,
  parameter int unsigned E_PULSE_CYCLES    = 25,
  parameter int unsigned CMD_WAIT_CYCLES   = 2_500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100_000
) (
  input  logic         clk,
  input  logic         rst,            // asynchronous, active-low
  input  logic [127:0] line1,          // [127:120] = column 0
  input  logic [127:0] line2,
  input  logic         force_refresh,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         busy,
  output logic         frame_done
);

  // One counter serves the power-up wait, the E pulse and the post-write wait,
  // so it is sized for the longest of them.
  localparam int unsigned MAX_A   = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ?
                                    POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYCLES > E_PULSE_CYCLES) ?
                                    CMD_WAIT_CYCLES : E_PULSE_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t PWR_LAST   = cnt_t'(POWERUP_CYCLES - 1);
  localparam cnt_t EHIGH_LAST = cnt_t'(E_PULSE_CYCLES - 1);
  localparam cnt_t CMD_LAST   = cnt_t'(CMD_WAIT_CYCLES - 1);
  localparam cnt_t CLEAR_LAST = cnt_t'(CLEAR_WAIT_CYCLES - 1);

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ADDR_L1  = 8'h80;
  localparam logic [7:0] CMD_ADDR_L2  = 8'hC0;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_ADDR1,
    S_CHAR1,
    S_ADDR2,
    S_CHAR2
  } state_e;

  // Phases of the byte transfer shared by every command and character write.
  typedef enum logic [1:0] {
    P_SETUP,
    P_EHIGH,
    P_HOLD,
    P_WAIT
  } phase_e;

  // Text line as 16 bytes; element 15 is column 0, matching the input packing.
  typedef logic [15:0][7:0] text_t;

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] init_idx_q, init_idx_d;
  logic [3:0] col_q, col_d;
  text_t      shadow1_q, shadow1_d;
  text_t      shadow2_q, shadow2_d;
  logic       force_pend_q, force_pend_d;

  logic       lcd_e_q, lcd_e_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic [7:0] lcd_data_q, lcd_data_d;
  logic       init_done_q, init_done_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;

  logic       byte_done;
  logic       text_changed;
  cnt_t       wait_last;
  logic [8:0] next_xfer;

  // States in which the byte-transfer phases are running.
  function automatic logic in_xfer(input state_e st);
    return (st == S_INIT) || (st == S_ADDR1) || (st == S_CHAR1) ||
           (st == S_ADDR2) || (st == S_CHAR2);
  endfunction

  // {rs, data} of the byte a transfer state sends for a given index/column.
  function automatic logic [8:0] xfer_byte(input state_e st, input logic [1:0] idx,
                                           input logic [3:0] col, input text_t l1,
                                           input text_t l2);
    logic [8:0] b;
    b = 9'h000;
    unique case (st)
      S_INIT: begin
        unique case (idx)
          2'd0: b = {1'b0, CMD_FUNC_SET};
          2'd1: b = {1'b0, CMD_DISP_ON};
          2'd2: b = {1'b0, CMD_ENTRY};
          2'd3: b = {1'b0, CMD_CLEAR};
        endcase
      end
      S_ADDR1: b = {1'b0, CMD_ADDR_L1};
      S_CHAR1: b = {1'b1, l1[4'd15 - col]};
      S_ADDR2: b = {1'b0, CMD_ADDR_L2};
      S_CHAR2: b = {1'b1, l2[4'd15 - col]};
      default: b = 9'h000;
    endcase
    return b;
  endfunction

  assign text_changed = ({line1, line2} != {shadow1_q, shadow2_q});

  // The clear command needs the long wait; every other byte uses the short one.
  // rs/data are held through the whole transfer, so they identify the byte.
  assign wait_last = (!lcd_rs_q && (lcd_data_q == CMD_CLEAR)) ? CLEAR_LAST : CMD_LAST;

  // Next-state logic for the sequencer and the registered LCD outputs.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statements can leave one unassigned and infer a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    init_idx_d   = init_idx_q;
    col_d        = col_q;
    shadow1_d    = shadow1_q;
    shadow2_d    = shadow2_q;
    force_pend_d = force_pend_q | force_refresh;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    byte_done    = 1'b0;
    lcd_rs_d     = lcd_rs_q;
    lcd_data_d   = lcd_data_q;
    next_xfer    = 9'h000;

    unique case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d    = S_INIT;
          phase_d    = P_SETUP;
          cnt_d      = '0;
          init_idx_d = 2'd0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_IDLE: begin
        // A refresh pulse landing on the snapshot cycle is consumed by it.
        if (text_changed || force_pend_q || force_refresh) begin
          shadow1_d    = line1;
          shadow2_d    = line2;
          force_pend_d = 1'b0;
          state_d      = S_ADDR1;
          phase_d      = P_SETUP;
          cnt_d        = '0;
        end
      end

      default: begin
        unique case (phase_q)
          P_SETUP: begin
            phase_d = P_EHIGH;
            cnt_d   = '0;
          end
          P_EHIGH: begin
            if (cnt_q == EHIGH_LAST) begin
              phase_d = P_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + cnt_t'(1);
            end
          end
          P_HOLD: begin
            phase_d = P_WAIT;
            cnt_d   = '0;
          end
          P_WAIT: begin
            if (cnt_q == wait_last) begin
              byte_done = 1'b1;
            end else begin
              cnt_d = cnt_q + cnt_t'(1);
            end
          end
        endcase

        if (byte_done) begin
          phase_d = P_SETUP;
          cnt_d   = '0;
          unique case (state_q)
            S_INIT: begin
              if (init_idx_q == 2'd3) begin
                state_d     = S_IDLE;
                init_done_d = 1'b1;
              end else begin
                init_idx_d = init_idx_q + 2'd1;
              end
            end
            S_ADDR1: begin
              state_d = S_CHAR1;
              col_d   = 4'd0;
            end
            S_CHAR1: begin
              col_d = col_q + 4'd1;
              if (col_q == 4'd15) state_d = S_ADDR2;
            end
            S_ADDR2: begin
              state_d = S_CHAR2;
              col_d   = 4'd0;
            end
            S_CHAR2: begin
              col_d = col_q + 4'd1;
              if (col_q == 4'd15) begin
                state_d      = S_IDLE;
                frame_done_d = 1'b1;
              end
            end
            default: state_d = state_q;
          endcase
        end
      end
    endcase

    // Outputs are computed from the next state so the registers present them
    // in the same cycle the sequencer enters the corresponding phase.
    lcd_e_d = in_xfer(state_d) && (phase_d == P_EHIGH);
    busy_d  = (state_d != S_IDLE);
    if (in_xfer(state_d) && (phase_d == P_SETUP)) begin
      next_xfer  = xfer_byte(state_d, init_idx_d, col_d, shadow1_q, shadow2_q);
      lcd_rs_d   = next_xfer[8];
      lcd_data_d = next_xfer[7:0];
    end
  end

  // State, counters, text shadow and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_PWR_WAIT;
      phase_q      <= P_SETUP;
      cnt_q        <= '0;
      init_idx_q   <= 2'd0;
      col_q        <= 4'd0;
      // NOTE: the shadow text is reset (not left undefined) because its
      // all-spaces value is part of the change comparison after reset.
      shadow1_q    <= {16{ASCII_SPACE}};
      shadow2_q    <= {16{ASCII_SPACE}};
      force_pend_q <= 1'b1;
      lcd_e_q      <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      col_q        <= col_d;
      shadow1_q    <= shadow1_d;
      shadow2_q    <= shadow2_d;
      force_pend_q <= force_pend_d;
      lcd_e_q      <= lcd_e_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_data_q   <= lcd_data_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lcd_e      = lcd_e_q;
  assign lcd_rs     = lcd_rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = lcd_data_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_text_controller.sv
// Testbench for lcd_text_controller: a scoreboard queue holds the expected LCD
// bus bytes (with expected timing), a monitor pops one per lcd_e rising edge.
module tb_lcd_text_controller;

  localparam int PWR   = 20;
  localparam int EPW   = 2;
  localparam int CMDW  = 4;
  localparam int CLRW  = 10;
  localparam int PITCH = 2 + EPW + CMDW;   // 8 cycles per ordinary byte

  logic         clk;
  logic         rst;
  logic [127:0] line1;
  logic [127:0] line2;
  logic         force_refresh;
  logic         lcd_e;
  logic         lcd_rs;
  logic         lcd_rw;
  logic [7:0]   lcd_data;
  logic         init_done;
  logic         busy;
  logic         frame_done;

  lcd_text_controller #(
    .POWERUP_CYCLES   (PWR),
    .E_PULSE_CYCLES   (EPW),
    .CMD_WAIT_CYCLES  (CMDW),
    .CLEAR_WAIT_CYCLES(CLRW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .line1        (line1),
    .line2        (line2),
    .force_refresh(force_refresh),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_data     (lcd_data),
    .init_done    (init_done),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gap > 0: cycles since previous lcd_e rise; gap < 0: -(cycles since reset
  // release); gap == 0: timing not checked.
  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } xfer_t;

  xfer_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rst_cyc = 0;
  int last_rise = 0;
  int rise_cnt = 0;
  logic e_prev = 1'b0;

  localparam logic [127:0] L1A = "PRESS * TO START";
  localparam logic [127:0] L2A = "MONEY: 01000    ";
  localparam logic [127:0] L2B = "MONEY: 01005    ";
  localparam logic [127:0] L1B = "PRESS # TO START";
  localparam logic [127:0] L1C = "GAME OVER       ";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] data, input int gap);
    xfer_t x;
    x.rs   = rs;
    x.data = data;
    x.gap  = gap;
    exp_q.push_back(x);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, -(PWR + 1));
    push(1'b0, 8'h0C, PITCH);
    push(1'b0, 8'h06, PITCH);
    push(1'b0, 8'h01, PITCH);
  endtask

  task automatic push_frame(input logic [127:0] l1, input logic [127:0] l2, input int first_gap);
    push(1'b0, 8'h80, first_gap);
    for (int c = 0; c < 16; c++) push(1'b1, l1[127 - 8*c -: 8], PITCH);
    push(1'b0, 8'hC0, PITCH);
    for (int c = 0; c < 16; c++) push(1'b1, l2[127 - 8*c -: 8], PITCH);
  endtask

  // Cycle counters: free-running, and since the last reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) rst_cyc = 0;
    else rst_cyc++;
  end
  always @(posedge clk) cyc++;

  // Bus monitor: scoreboard pop on each lcd_e rise, pulse width on each fall.
  always @(negedge clk) begin
    if (rst && lcd_e && !e_prev) begin
      xfer_t x;
      rise_cnt++;
      check("byte_expected", exp_q.size() > 0, 1'b1);
      check("rw_low", lcd_rw, 1'b0);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("bus_byte", {lcd_rs, lcd_data}, {x.rs, x.data});
        if (x.gap > 0) check("byte_gap", cyc - last_rise, x.gap);
        if (x.gap < 0) check("powerup_gap", rst_cyc, -x.gap);
      end
      last_rise = cyc;
    end
    if (rst && !lcd_e && e_prev) check("e_width", cyc - last_rise, EPW);
    e_prev = lcd_e;
  end

  task automatic wait_init(input int budget);
    for (int i = 0; i < budget && !init_done; i++) @(negedge clk);
    check("init_done", init_done, 1'b1);
    if (init_done) begin
      check("init_gap", cyc - last_rise, CLRW + 3);
      check("init_busy", busy, 1'b0);
    end
  endtask

  task automatic wait_frame(input int budget, input int left);
    for (int i = 0; i < budget && !frame_done; i++) @(negedge clk);
    check("frame_done", frame_done, 1'b1);
    if (frame_done) begin
      check("frame_gap", cyc - last_rise, PITCH - 1);
      check("queue_left", exp_q.size(), left);
      @(negedge clk);
      check("frame_done_width", frame_done, 1'b0);
    end
  endtask

  task automatic expect_quiet(input int cycles);
    int r0;
    r0 = rise_cnt;
    repeat (cycles) @(negedge clk);
    check("quiet_no_e", rise_cnt - r0, 0);
    check("quiet_busy", busy, 1'b0);
  endtask

  initial begin
    rst           = 1'b0;
    line1         = L1A;
    line2         = L2A;
    force_refresh = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, busy, frame_done},
          {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});

    // Power-up, init and the first frame.
    push_init();
    push_frame(L1A, L2A, CLRW + 5);
    rst = 1'b1;
    wait_init(400);
    wait_frame(1000, 0);

    // Unchanged text: the panel is left alone.
    expect_quiet(1000);

    // One character of line 2 changes: exactly one new frame.
    line2 = L2B;
    push_frame(L1A, L2B, 0);
    wait_frame(1000, 0);
    expect_quiet(50);

    // Line 1 changes, and changes again while column 5 is being written.
    line1 = L1B;
    push_frame(L1B, L2B, 0);
    for (int i = 0; i < 1000 && exp_q.size() > 27; i++) @(negedge clk);
    check("mid_frame_reached", exp_q.size(), 27);
    line1 = L1C;
    push_frame(L1C, L2B, PITCH + 1);
    wait_frame(1000, 34);
    wait_frame(1000, 0);
    expect_quiet(50);

    // Forced refresh with unchanged text: one identical frame.
    force_refresh = 1'b1;
    push_frame(L1C, L2B, 0);
    @(negedge clk);
    force_refresh = 1'b0;
    wait_frame(1000, 0);
    expect_quiet(100);

    // Reset during the E pulse of a line-2 character.
    force_refresh = 1'b1;
    push_frame(L1C, L2B, 0);
    @(negedge clk);
    force_refresh = 1'b0;
    for (int i = 0; i < 1000 && !(lcd_e && exp_q.size() <= 8); i++) @(negedge clk);
    check("abort_point_e", lcd_e, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_e_low", lcd_e, 1'b0);
    check("abort_init_done", init_done, 1'b0);
    check("abort_busy", busy, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_init();
    push_frame(L1C, L2B, CLRW + 5);
    rst = 1'b1;
    wait_init(400);
    wait_frame(1000, 0);
    expect_quiet(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

endmodule
